// File: rtl/mips16_pkg.sv
// Shared constants and types for the mips16 datapath blocks, including
// the restoring divider's state encoding and iteration-counter sizing.
package mips16_pkg;

    localparam int DIV_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div16_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div16_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // i_rem < i_div always holds, so a borrow shows up in the top bit of w_diff
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_div};
        if (w_diff[WIDTH]) begin
            o_rem  = w_shift[WIDTH-1:0];
            o_qbit = 1'b0;
        end else begin
            o_rem  = w_diff[WIDTH-1:0];
            o_qbit = 1'b1;
        end
    end

endmodule

// File: rtl/div16.sv
// Iterative restoring divider, one quotient bit per cycle, with signed /
// unsigned modes, divide-by-zero flag and valid/ready handshakes.
module div16
    import mips16_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz
);

    localparam int               CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_qbit;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_b_zero;

    // Operand magnitudes; negating the most negative value wraps to itself,
    // which is exactly the unsigned magnitude needed for the overflow case.
    always_comb begin
        w_abs_a    = neg_if(a, sgn & a[WIDTH-1]);
        w_abs_b    = neg_if(b, sgn & b[WIDTH-1]);
        w_b_zero   = (b == {WIDTH{1'b0}});
        w_quo_next = {r_quo[WIDTH-2:0], w_step_qbit};
    end

    div16_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    // Control FSM plus datapath registers; r_quo holds the dividend and fills with quotient bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_rem     <= {WIDTH{1'b0}};
            r_quo     <= {WIDTH{1'b0}};
            r_div     <= {WIDTH{1'b0}};
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            q         <= {WIDTH{1'b0}};
            r         <= {WIDTH{1'b0}};
            dz        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (w_b_zero) begin
                            r_state   <= DONE;
                            q         <= {WIDTH{1'b1}};
                            r         <= a;
                            dz        <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= {CNT_W{1'b0}};
                            r_rem   <= {WIDTH{1'b0}};
                            r_quo   <= w_abs_a;
                            r_div   <= w_abs_b;
                            r_neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= sgn & a[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_quo_next;
                    if (r_cnt == LAST_ITER) begin
                        r_cnt     <= {CNT_W{1'b0}};
                        r_state   <= DONE;
                        q         <= neg_if(w_quo_next, r_neg_q);
                        r         <= neg_if(w_step_rem, r_neg_r);
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= {CNT_W{1'b0}};
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
